wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Sits directly upstream of the register file write port.
- Merges two result sources onto the single GPR write port (we/wa/wd):
  - the in-order main pipeline, which is never stalled;
  - a long-latency unit (mul/div, uncached load), which uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a per-register busy scoreboard, so the hazard unit can stall readers of registers that still have outstanding long-latency results.

Parameters:
- FIFO_DEPTH, 2, entries in the long-latency result buffer (power of two, ≥2).
- DATA_W, 32, result data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- p_valid  input  1  pipeline result valid this cycle.
- p_wa  input  5  pipeline destination register.
- p_wd  input  DATA_W  pipeline result data.
- l_issue  input  1  long-latency op issued this cycle; reserves l_issue_wa.
- l_issue_wa  input  5  destination reserved by the issuing op.
- l_valid  input  1  long-latency result offered.
- l_ready  output  1  arbiter accepts the offered result.
- l_wa  input  5  long-latency result destination.
- l_wd  input  DATA_W  long-latency result data.
- rs  input  5  hazard query, source 1.
- rt  input  5  hazard query, source 2.
- rs_busy  output  1  rs has an outstanding long-latency write.
- rt_busy  output  1  rt has an outstanding long-latency write.
- we  output  1  GPR write enable.
- wa  output  5  GPR write address.
- wd  output  DATA_W  GPR write data.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  buffered result count.
- err  output  1  sticky protocol error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied; fifo_count=0.
  - Scoreboard cleared; err=0.
  - we forced 0 combinationally while rst is low.
  - Long-latency ops in flight are discarded; the long-latency unit is reset by the same rst.
- Write port selection is combinational and lands on the same rising edge (zero added latency). Priority:
  1. Pipeline write: p_valid=1 and p_wa≠0. Outputs we=1, wa=p_wa, wd=p_wd.
  2. FIFO head, if fifo_count>0. Pops the head at the edge.
  3. Bypass: fifo_count=0, l_valid=1, l_wa≠0. Writes l_wa/l_wd directly; nothing is enqueued.
  4. Otherwise we=0, wa=0, wd=0.
- Register 0 is never written. A source with destination 0 never asserts we.
- A FIFO head with wa=0 is popped in its grant slot with we=0.
- l_ready = (fifo_count < FIFO_DEPTH). It does not depend on a same-cycle pop.
- Handshake: transfer occurs when l_valid && l_ready at the edge.
  - If the bypass was granted that cycle, the transfer is consumed by the bypass.
  - Otherwise the result is enqueued at the tail.
  - Enqueue and pop in the same cycle leave fifo_count unchanged.
- FIFO ordering is strict; long-latency results retire in acceptance order.
- Scoreboard: 32-bit busy vector; bit 0 is hard-wired 0.
  - l_issue=1 with l_issue_wa≠0 sets busy[l_issue_wa] at the edge.
  - A long-latency write to GPR (FIFO pop or bypass) clears busy[wa] at the edge.
  - Set and clear of the same index in the same cycle: set wins.
- Hazard query: rs_busy=busy[rs], rt_busy=busy[rt], combinational from registered state.
  - busy stays 1 during the cycle in which the write occurs, so a same-cycle reader still stalls.
- err is set, sticky until reset, on any of:
  - l_issue to an already-busy register;
  - a pipeline write to a busy register (WAW);
  - a long-latency write to a non-busy register.
  - The offending writes are still performed.
- Starvation: continuous pipeline writes starve the FIFO indefinitely. This is legal; backpressure via l_ready is the only throttle.

Test Plan:
- Reset then idle:
  - rst low mid-run with FIFO holding 2 entries → fifo_count=0, we=0, rs_busy=0 for all rs, l_ready=1 after release.
- Bypass:
  - l_issue wa=5.
  - Next cycle l_valid, l_wa=5, l_wd=0xDEADBEEF, no pipe write → same edge we=1, wa=5, wd=0xDEADBEEF; busy[5] cleared; fifo_count stays 0.
- Contention:
  - p_valid wa=3 wd=1 and l_valid wa=7 wd=2 in the same cycle → pipe writes r3; r7 enqueued (fifo_count=1); r7 written next idle cycle.
- Backpressure:
  - Hold p_valid for 4 cycles while offering 3 long results → first 2 accepted, l_ready=0 on the third.
  - Release the pipe → results written in order; l_ready returns to 1 after the first pop.
- Scoreboard timing:
  - Issue wa=9, query rs=9 → rs_busy=1 from the next cycle through the write cycle, 0 the cycle after.
  - Issue and write r9 in the same cycle → busy[9] remains 1.
- Register 0 and errors:
  - Pipe write wa=0 → we=0.
  - Issue r4 twice → err=1 and stays 1 until rst low.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and buffered long-latency results onto one GPR write port with a busy scoreboard.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p_valid,
    input  logic [4:0]                    p_wa,
    input  logic [DATA_W-1:0]             p_wd,
    input  logic                          l_issue,
    input  logic [4:0]                    l_issue_wa,
    input  logic                          l_valid,
    output logic                          l_ready,
    input  logic [4:0]                    l_wa,
    input  logic [DATA_W-1:0]             l_wd,
    input  logic [4:0]                    rs,
    input  logic [4:0]                    rt,
    output logic                          rs_busy,
    output logic                          rt_busy,
    output logic                          we,
    output logic [4:0]                    wa,
    output logic [DATA_W-1:0]             wd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]        mem_wa_q [FIFO_DEPTH];
    logic [4:0]        mem_wa_d [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_wd_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_wd_d [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       busy_q, busy_d;
    logic              err_q, err_d;
    logic [4:0]        head_wa, l_wr_wa;
    logic [DATA_W-1:0] head_wd;
    logic              p_wr, pop, byp, enq, l_wr;

    always_comb begin
        head_wa = mem_wa_q[rd_ptr_q];
        head_wd = mem_wd_q[rd_ptr_q];
        p_wr    = p_valid && (p_wa != 5'd0);
        pop     = !p_wr && (count_q != '0);
        byp     = !p_wr && (count_q == '0) && l_valid && (l_wa != 5'd0);
        l_ready = count_q < CW'(FIFO_DEPTH);
        enq     = l_valid && l_ready && !byp;
        l_wr    = (pop && (head_wa != 5'd0)) || byp;
        l_wr_wa = pop ? head_wa : l_wa;
        we      = rst && (p_wr || l_wr);
        wa      = p_wr ? p_wa : pop ? head_wa : byp ? l_wa : 5'd0;
        wd      = p_wr ? p_wd : pop ? head_wd : byp ? l_wd : '0;
        rs_busy = busy_q[rs];
        rt_busy = busy_q[rt];
        fifo_count = count_q;
        err     = err_q;
    end

    always_comb begin
        mem_wa_d = mem_wa_q;
        mem_wd_d = mem_wd_q;
        if (enq) begin
            mem_wa_d[wr_ptr_q] = l_wa;
            mem_wd_d[wr_ptr_q] = l_wd;
        end
        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(enq) - CW'(pop);
        // clear before set so a same-cycle reissue keeps the register busy
        busy_d = busy_q;
        if (l_wr) busy_d[l_wr_wa] = 1'b0;
        if (l_issue) busy_d[l_issue_wa] = 1'b1;
        busy_d[0] = 1'b0;
        err_d = err_q || (l_issue && busy_q[l_issue_wa]) || (p_wr && busy_q[p_wa])
                || (l_wr && !busy_q[l_wr_wa]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wa_q <= '{default: '0};
            mem_wd_q <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            mem_wa_q <= mem_wa_d;
            mem_wd_q <= mem_wd_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end
endmodule
